button_cmd_ctrl: RTL and testbench

Front-panel command controller for the DSP. Takes three debounced push-button levels (up, down, select) from the debouncer stage and turns them into edge events with hold-to-repeat. It sequences a two-field edit cycle (filter mode, then gain) and commits the edited configuration to the DSP datapath over a valid/ready handshake. It sits between the debouncers and the datapath configuration registers.

---
 rtl/button_cmd_ctrl.sv | 135 +++++++++++++
 tb/tb_button_cmd_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/button_cmd_ctrl.sv
// Front-panel command controller: button edge/auto-repeat events drive a two-field
// edit cycle (mode, gain) that is committed to the datapath over valid/ready.
module button_cmd_ctrl #(
  parameter int unsigned TICK_BITS    = 19,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned MODE_W       = 2,
  parameter int unsigned GAIN_W       = 4,
  parameter int unsigned GAIN_INIT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_sel,
  input  logic              cfg_ready,
  output logic              cfg_valid,
  output logic [MODE_W-1:0] edit_mode,
  output logic [GAIN_W-1:0] edit_gain,
  output logic [MODE_W-1:0] cfg_mode,
  output logic [GAIN_W-1:0] cfg_gain,
  output logic [1:0]        field
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [GAIN_W-1:0] GainMax  = '1;
  localparam logic [GAIN_W-1:0] GainRst  = GAIN_W'(GAIN_INIT);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HoldLoad = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);

  typedef enum logic [1:0] {StMode = 2'd0, StGain = 2'd1, StCommit = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [TICK_BITS-1:0] tick_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                up_q, down_q, sel_q;
  logic [MODE_W-1:0]   edit_mode_q, edit_mode_d, cfg_mode_q, cfg_mode_d;
  logic [GAIN_W-1:0]   edit_gain_q, edit_gain_d, cfg_gain_q, cfg_gain_d;

  logic tick, ud_onehot, ud_stable, rpt, up_ev, down_ev, sel_ev;

  assign tick      = &tick_q;
  assign ud_onehot = btn_up ^ btn_down;
  assign ud_stable = (btn_up == up_q) && (btn_down == down_q);

  // Shared hold counter; repeat fires on the tick that would bring it to HOLD_TICKS.
  always_comb begin
    hold_d = hold_q;
    rpt    = 1'b0;
    if (!ud_stable || !ud_onehot) begin
      hold_d = '0;
    end else if (tick) begin
      if (hold_q == HoldLast) begin
        rpt    = 1'b1;
        hold_d = HoldLoad;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  assign up_ev   = (btn_up & ~up_q) | (rpt & btn_up);
  assign down_ev = (btn_down & ~down_q) | (rpt & btn_down);
  assign sel_ev  = btn_sel & ~sel_q;

  always_comb begin
    state_d     = state_q;
    edit_mode_d = edit_mode_q;
    edit_gain_d = edit_gain_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_gain_d  = cfg_gain_q;
    unique case (state_q)
      StMode: begin
        if (sel_ev) begin
          state_d = StGain;
        end else if (up_ev && !down_ev) begin
          edit_mode_d = edit_mode_q + 1'b1;
        end else if (down_ev && !up_ev) begin
          edit_mode_d = edit_mode_q - 1'b1;
        end
      end
      StGain: begin
        if (sel_ev) begin
          state_d = StCommit;
        end else if (up_ev && !down_ev && edit_gain_q != GainMax) begin
          edit_gain_d = edit_gain_q + 1'b1;
        end else if (down_ev && !up_ev && edit_gain_q != '0) begin
          edit_gain_d = edit_gain_q - 1'b1;
        end
      end
      StCommit: begin
        if (cfg_ready) begin
          cfg_mode_d = edit_mode_q;
          cfg_gain_d = edit_gain_q;
          state_d    = StMode;
        end
      end
      default: state_d = StMode;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StMode;
      tick_q      <= '0;
      hold_q      <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      sel_q       <= 1'b0;
      edit_mode_q <= '0;
      edit_gain_q <= GainRst;
      cfg_mode_q  <= '0;
      cfg_gain_q  <= GainRst;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_q + 1'b1;
      hold_q      <= hold_d;
      up_q        <= btn_up;
      down_q      <= btn_down;
      sel_q       <= btn_sel;
      edit_mode_q <= edit_mode_d;
      edit_gain_q <= edit_gain_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_gain_q  <= cfg_gain_d;
    end
  end

  assign cfg_valid = (state_q == StCommit);
  assign field     = state_q;
  assign edit_mode = edit_mode_q;
  assign edit_gain = edit_gain_q;
  assign cfg_mode  = cfg_mode_q;
  assign cfg_gain  = cfg_gain_q;

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Directed bench for button_cmd_ctrl with a short tick period (8 cycles).
module tb_button_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_sel, cfg_ready, cfg_valid;
  logic [1:0] edit_mode, cfg_mode, field;
  logic [3:0] edit_gain, cfg_gain;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  button_cmd_ctrl #(
    .TICK_BITS(3), .HOLD_TICKS(4), .REPEAT_TICKS(2), .MODE_W(2), .GAIN_W(4), .GAIN_INIT(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .cfg_ready(cfg_ready), .cfg_valid(cfg_valid), .edit_mode(edit_mode),
    .edit_gain(edit_gain), .cfg_mode(cfg_mode), .cfg_gain(cfg_gain), .field(field)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Edges after reset release are numbered from 1; ticks land on edges with edge_n % 8 == 0.
  task automatic cyc();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  initial begin
    logic [1:0] mode_seq [5];
    mode_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; cfg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    edge_n = 0;

    check("rst_field", 8'(field), 8'd0);
    check("rst_valid", 8'(cfg_valid), 8'd0);
    check("rst_edit_mode", 8'(edit_mode), 8'd0);
    check("rst_edit_gain", 8'(edit_gain), 8'd8);
    check("rst_cfg_mode", 8'(cfg_mode), 8'd0);
    check("rst_cfg_gain", 8'(cfg_gain), 8'd8);

    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1; cyc();
      check("up_mode", 8'(edit_mode), 8'(mode_seq[i]));
      check("up_cfg_mode", 8'(cfg_mode), 8'd0);
      check("up_valid", 8'(cfg_valid), 8'd0);
      btn_up = 1'b0; cyc();
    end
    btn_up = 1'b1; cyc();
    check("mode_to_2", 8'(edit_mode), 8'd2);
    btn_up = 1'b0; cyc();

    btn_sel = 1'b1; btn_up = 1'b1; cyc();
    check("sel_up_field", 8'(field), 8'd1);
    check("sel_up_mode", 8'(edit_mode), 8'd2);
    btn_sel = 1'b0; btn_up = 1'b0; cyc();
    check("sel_up_gain", 8'(edit_gain), 8'd8);

    // Align so the press edge P is the edge right after a tick: ticks at P+7, P+15, ...
    while (edge_n % 8 != 0) cyc();
    btn_down = 1'b1; cyc();
    check("hold_press", 8'(edit_gain), 8'd7);
    repeat (30) cyc();
    check("hold_p30", 8'(edit_gain), 8'd7);
    cyc();
    check("hold_first_rpt", 8'(edit_gain), 8'd6);
    repeat (15) cyc();
    check("hold_p46", 8'(edit_gain), 8'd6);
    cyc();
    check("hold_rpt2", 8'(edit_gain), 8'd5);
    repeat (16) cyc();
    check("hold_rpt3", 8'(edit_gain), 8'd4);
    btn_down = 1'b0; cyc();
    check("hold_release", 8'(edit_gain), 8'd4);

    for (int i = 0; i < 7; i++) begin
      btn_down = 1'b1; cyc();
      check("down_sat", 8'(edit_gain), (i < 4) ? 8'(3 - i) : 8'd0);
      btn_down = 1'b0; cyc();
    end

    btn_up = 1'b1; btn_down = 1'b1; cyc();
    check("up_down_cancel", 8'(edit_gain), 8'd0);
    check("up_down_field", 8'(field), 8'd1);
    btn_up = 1'b0; btn_down = 1'b0; cyc();

    for (int i = 0; i < 11; i++) begin
      btn_up = 1'b1; cyc();
      check("gain_up", 8'(edit_gain), 8'(i + 1));
      btn_up = 1'b0; cyc();
    end

    btn_sel = 1'b1; cyc();
    check("commit_field", 8'(field), 8'd2);
    check("commit_valid", 8'(cfg_valid), 8'd1);
    btn_sel = 1'b0; cyc();

    for (int i = 0; i < 10; i++) begin
      btn_up = i[0]; btn_down = ~i[0]; btn_sel = i[0]; cyc();
      check("stall_valid", 8'(cfg_valid), 8'd1);
      check("stall_mode", 8'(edit_mode), 8'd2);
      check("stall_gain", 8'(edit_gain), 8'd11);
      check("stall_field", 8'(field), 8'd2);
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; cyc();
    check("stall_cfg_gain", 8'(cfg_gain), 8'd8);

    cfg_ready = 1'b1; cyc();
    check("hs_cfg_mode", 8'(cfg_mode), 8'd2);
    check("hs_cfg_gain", 8'(cfg_gain), 8'd11);
    check("hs_valid", 8'(cfg_valid), 8'd0);
    check("hs_field", 8'(field), 8'd0);

    // cfg_ready already high: handshake completes on the first COMMIT cycle.
    btn_sel = 1'b1; cyc(); btn_sel = 1'b0; cyc();
    check("adv_field_gain", 8'(field), 8'd1);
    btn_sel = 1'b1; cyc();
    check("adv_valid", 8'(cfg_valid), 8'd1);
    btn_sel = 1'b0; cyc();
    check("adv_done_valid", 8'(cfg_valid), 8'd0);
    check("adv_done_field", 8'(field), 8'd0);

    cfg_ready = 1'b0;
    btn_sel = 1'b1; cyc(); btn_sel = 1'b0; cyc();
    btn_sel = 1'b1; cyc();
    check("pre_rst_valid", 8'(cfg_valid), 8'd1);
    btn_sel = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 8'(cfg_valid), 8'd0);
    check("async_rst_field", 8'(field), 8'd0);
    check("async_rst_cfg_gain", 8'(cfg_gain), 8'd8);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc();
    check("post_rst_mode", 8'(edit_mode), 8'd0);
    check("post_rst_gain", 8'(edit_gain), 8'd8);
    check("post_rst_cfg_gain", 8'(cfg_gain), 8'd8);
    check("post_rst_cfg_mode", 8'(cfg_mode), 8'd0);
    check("post_rst_valid", 8'(cfg_valid), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
